mc_main_fsm: RTL
================

// Module: mc_main_fsm
// PURPOSE
//  Multicycle MIPS main controller: Moore FSM sequencing FETCH/DECODE/execute/writeback per instruction.
//  Sits beside the datapath and ALU decoder, replacing the single-cycle opcode decoder.
//  Adds a memory-ready handshake, optional BNE, and illegal-opcode trap that single-cycle decode lacks.
// PARAMETERS
//  MEM_WAIT  1  1: FETCH/MEMRD/MEMWR stall until mem_ready_i; 0: mem_ready_i ignored (treated as 1)
//  EN_BNE    1  1: BNE (000101) decoded via BRANCH state with branch_ne_o; 0: BNE is illegal
//  ST_W      4  width of state_o4 (fixed encoding below, must be >=4)
// PORTS
//  clk_i          in   1  clock, all state on rising edge
//  rst_i          in   1  synchronous, active-high reset
//  op_i6          in   6  opcode from instruction register (valid from DECODE onward)
//  mem_ready_i    in   1  memory completes access this cycle
//  iord_o         out  1  0: address=PC, 1: address=ALUOut
//  ir_write_o     out  1  load instruction register
//  mem_write_o    out  1  memory write enable
//  pc_write_o     out  1  unconditional PC load
//  branch_o       out  1  conditional PC load (datapath ANDs with zero / ~zero)
//  branch_ne_o    out  1  1 with branch_o: take on ~zero (BNE)
//  pc_src_o2      out  2  00 ALUResult, 01 ALUOut, 10 jump target
//  alu_src_a_o    out  1  0 PC, 1 reg A
//  alu_src_b_o2   out  2  00 reg B, 01 const 4, 10 SignImm, 11 SignImm<<2
//  alu_op_o2      out  2  00 add, 01 sub, 10 funct-decoded
//  reg_dst_o      out  1  0 rt, 1 rd
//  mem_to_reg_o   out  1  0 ALUOut, 1 Data
//  reg_write_o    out  1  register file write enable
//  illegal_o      out  1  one-cycle pulse: unsupported opcode in DECODE
//  state_o4       out  4  current state (debug)
// BEHAVIOUR
//  States: FETCH=0 DECODE=1 MEMADR=2 MEMRD=3 MEMWB=4 MEMWR=5 EXECUTE=6 ALUWB=7 BRANCH=8 ADDIEX=9 ADDIWB=10 JUMP=11.
//  Codes 12-15 unreachable; if entered, next state FETCH with all outputs 0.
//  Moore: outputs depend on state only, except ir_write_o/pc_write_o in FETCH and exit of wait states (gated by ready).
//  rdy = MEM_WAIT ? mem_ready_i : 1.
//  Every output not listed for a state is 0.
//  FETCH: alu_src_b=01, ir_write=pc_write=rdy; rdy -> DECODE, else stay.
//  DECODE: alu_src_b=11; by op: LW/SW->MEMADR, RTYPE->EXECUTE, BEQ(/BNE)->BRANCH, ADDI->ADDIEX, J->JUMP.
//   Any other op (incl. BNE when EN_BNE=0): illegal_o=1 this cycle, next FETCH.
//  MEMADR: alu_src_a=1, alu_src_b=10; LW->MEMRD, SW->MEMWR.
//  MEMRD: iord=1; rdy -> MEMWB, else stay.
//  MEMWB: mem_to_reg=1, reg_write=1 -> FETCH.
//  MEMWR: iord=1, mem_write=1 held every cycle; rdy -> FETCH, else stay.
//  EXECUTE: alu_src_a=1, alu_op=10 -> ALUWB.  ALUWB: reg_dst=1, reg_write=1 -> FETCH.
//  BRANCH: alu_src_a=1, alu_op=01, pc_src=01, branch=1, branch_ne=(op==BNE) -> FETCH.
//  ADDIEX: alu_src_a=1, alu_src_b=10 -> ADDIWB.  ADDIWB: reg_write=1 -> FETCH.
//  JUMP: pc_src=10, pc_write=1 -> FETCH.
//  Opcode encodings from mips_defs.sv (`INSTR_*); op_i6 sampled in DECODE and MEMADR only.
//  Cycle counts (rdy=1): LW 5, SW 4, R 4, ADDI 4, BEQ/BNE 3, J 3, illegal 2.
//  Reset: rst_i high at any edge forces FETCH next cycle, overrides stalls mid-access; while in reset
//   state_o4=0 and all outputs 0 (ir_write/pc_write suppressed until the first cycle after rst_i low).
//  No output X in any state; no latches.
// TESTING
//  Reset: rst_i=1 2 cycles -> state_o4=0, all outputs 0; release -> FETCH with ir_write_o=pc_write_o=1.
//  LW op=100011, rdy=1 -> states 0,1,2,3,4,0; MEMWB shows mem_to_reg_o=1 reg_write_o=1 reg_dst_o=0.
//  MEM_WAIT=1, SW op=101011, mem_ready_i low 3 cycles in MEMWR -> mem_write_o=1 for 4 cycles, then FETCH.
//  BNE op=000101: EN_BNE=1 -> BRANCH with branch_o=branch_ne_o=1 pc_src_o2=01; EN_BNE=0 -> illegal_o pulse, FETCH.
//  Illegal op=111111 -> illegal_o=1 in DECODE only, no reg_write/mem_write, back to FETCH in 2 cycles.
//  rst_i asserted in MEMRD while stalled -> next cycle state 0, iord_o=0, no writes issued.

Source files
------------

// File: rtl/mc_main_fsm.sv
// Multicycle MIPS main controller: Moore FSM sequencing fetch, decode, execute and
// writeback, with a memory-ready handshake, optional BNE and an illegal-opcode trap.
module mc_main_fsm #(
    parameter bit          MEM_WAIT = 1'b1,
    parameter bit          EN_BNE   = 1'b1,
    parameter int unsigned ST_W     = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [5:0]      op_i6,
    input  logic            mem_ready_i,
    output logic            iord_o,
    output logic            ir_write_o,
    output logic            mem_write_o,
    output logic            pc_write_o,
    output logic            branch_o,
    output logic            branch_ne_o,
    output logic [1:0]      pc_src_o2,
    output logic            alu_src_a_o,
    output logic [1:0]      alu_src_b_o2,
    output logic [1:0]      alu_op_o2,
    output logic            reg_dst_o,
    output logic            mem_to_reg_o,
    output logic            reg_write_o,
    output logic            illegal_o,
    output logic [ST_W-1:0] state_o4
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXECUTE = 4'd6,
        ALUWB   = 4'd7,
        BRANCH  = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JUMP    = 4'd11
    } state_t;

    state_t state_q;
    state_t state_d;
    logic   is_bne_q;
    logic   rdy;

    assign rdy = MEM_WAIT ? mem_ready_i : 1'b1;

    // State register; the BNE flag is captured in DECODE so BRANCH never looks at op_i6.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= FETCH;
            is_bne_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == DECODE) begin
                is_bne_q <= EN_BNE && (op_i6 == OP_BNE);
            end
        end
    end

    // Next-state and Moore control decode.
    always_comb begin
        state_d      = state_q;
        iord_o       = 1'b0;
        ir_write_o   = 1'b0;
        mem_write_o  = 1'b0;
        pc_write_o   = 1'b0;
        branch_o     = 1'b0;
        branch_ne_o  = 1'b0;
        pc_src_o2    = 2'b00;
        alu_src_a_o  = 1'b0;
        alu_src_b_o2 = 2'b00;
        alu_op_o2    = 2'b00;
        reg_dst_o    = 1'b0;
        mem_to_reg_o = 1'b0;
        reg_write_o  = 1'b0;
        illegal_o    = 1'b0;

        case (state_q)
            FETCH: begin
                alu_src_b_o2 = 2'b01;
                ir_write_o   = rdy;
                pc_write_o   = rdy;
                if (rdy) state_d = DECODE;
            end
            DECODE: begin
                alu_src_b_o2 = 2'b11;
                case (op_i6)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = EXECUTE;
                    OP_BEQ:       state_d = BRANCH;
                    OP_ADDI:      state_d = ADDIEX;
                    OP_J:         state_d = JUMP;
                    OP_BNE: begin
                        if (EN_BNE) begin
                            state_d = BRANCH;
                        end else begin
                            illegal_o = 1'b1;
                            state_d   = FETCH;
                        end
                    end
                    default: begin
                        illegal_o = 1'b1;
                        state_d   = FETCH;
                    end
                endcase
            end
            MEMADR: begin
                alu_src_a_o  = 1'b1;
                alu_src_b_o2 = 2'b10;
                if (op_i6 == OP_LW)      state_d = MEMRD;
                else if (op_i6 == OP_SW) state_d = MEMWR;
                else                     state_d = FETCH;
            end
            MEMRD: begin
                iord_o = 1'b1;
                if (rdy) state_d = MEMWB;
            end
            MEMWB: begin
                mem_to_reg_o = 1'b1;
                reg_write_o  = 1'b1;
                state_d      = FETCH;
            end
            MEMWR: begin
                iord_o      = 1'b1;
                mem_write_o = 1'b1;
                if (rdy) state_d = FETCH;
            end
            EXECUTE: begin
                alu_src_a_o = 1'b1;
                alu_op_o2   = 2'b10;
                state_d     = ALUWB;
            end
            ALUWB: begin
                reg_dst_o   = 1'b1;
                reg_write_o = 1'b1;
                state_d     = FETCH;
            end
            BRANCH: begin
                alu_src_a_o = 1'b1;
                alu_op_o2   = 2'b01;
                pc_src_o2   = 2'b01;
                branch_o    = 1'b1;
                branch_ne_o = is_bne_q;
                state_d     = FETCH;
            end
            ADDIEX: begin
                alu_src_a_o  = 1'b1;
                alu_src_b_o2 = 2'b10;
                state_d      = ADDIWB;
            end
            ADDIWB: begin
                reg_write_o = 1'b1;
                state_d     = FETCH;
            end
            JUMP: begin
                pc_src_o2  = 2'b10;
                pc_write_o = 1'b1;
                state_d    = FETCH;
            end
            default: state_d = FETCH;
        endcase

        // Reset cycle: every strobe is quiet, even if the register still holds a mid-access state.
        if (rst_i) begin
            iord_o       = 1'b0;
            ir_write_o   = 1'b0;
            mem_write_o  = 1'b0;
            pc_write_o   = 1'b0;
            branch_o     = 1'b0;
            branch_ne_o  = 1'b0;
            pc_src_o2    = 2'b00;
            alu_src_a_o  = 1'b0;
            alu_src_b_o2 = 2'b00;
            alu_op_o2    = 2'b00;
            reg_dst_o    = 1'b0;
            mem_to_reg_o = 1'b0;
            reg_write_o  = 1'b0;
            illegal_o    = 1'b0;
        end
    end

    assign state_o4 = rst_i ? '0 : ST_W'(state_q);

endmodule
